pc_stall_sequencer: RTL and testbench

- Controls the fetch-stage PC register and the IF/ID pipeline register in the 5-stage pipelined CPU.
- Provides the boot hold after reset.
- Detects load-use hazards and inserts a one-cycle stall.
- Redirects fetch on a taken branch resolved in ID and freezes fetch while instruction memory is not ready.
- Drives PCWrite, IFIDWrite, IF_Flush, ID_EX_bubble and the next-PC value.
- Keeps a saturating stall-cycle counter and a sticky fetch-timeout flag.

---
 rtl/pc_stall_sequencer_if.sv | 32 +++
 rtl/pc_stall_sequencer.sv | 102 ++++++++++
 tb/tb_pc_stall_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pc_stall_sequencer_if.sv
// pc_stall_sequencer_if: fetch-control bus between the IF/ID datapath and the stall sequencer
interface pc_stall_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      pc_plus4;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rd;
    logic [4:0]       if_id_rs;
    logic [4:0]       if_id_rt;
    logic             imem_ready;
    logic [31:0]      pc_next;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IF_Flush;
    logic             ID_EX_bubble;
    logic [CNT_W-1:0] stall_count;
    logic             timeout_flag;

    modport master (
        output pc_plus4, branch_taken, branch_target, id_ex_mem_read, id_ex_rd,
               if_id_rs, if_id_rt, imem_ready,
        input  pc_next, PCWrite, IFIDWrite, IF_Flush, ID_EX_bubble, stall_count, timeout_flag
    );

    modport slave (
        input  pc_plus4, branch_taken, branch_target, id_ex_mem_read, id_ex_rd,
               if_id_rs, if_id_rt, imem_ready,
        output pc_next, PCWrite, IFIDWrite, IF_Flush, ID_EX_bubble, stall_count, timeout_flag
    );
endinterface

// File: rtl/pc_stall_sequencer.sv
// pc_stall_sequencer: PC and IF/ID write control with boot hold, load-use stall, branch redirect and imem wait
module pc_stall_sequencer #(
    parameter int BOOT_CYCLES  = 2,
    parameter int WAIT_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input logic                 clk,
    input logic                 rst,
    pc_stall_sequencer_if.slave bus
);
    localparam int BW = $clog2(BOOT_CYCLES + 1);
    localparam int WW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [1:0] {BOOT, RUN, LU_STALL} state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    boot_cnt_q, boot_cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             timeout_q, timeout_d;
    logic             hazard;
    logic [31:0]      pc_next;
    logic             pc_write, ifid_write, if_flush, bubble;

    assign hazard = bus.id_ex_mem_read && (bus.id_ex_rd != 5'd0) &&
                    ((bus.id_ex_rd == bus.if_id_rs) || (bus.id_ex_rd == bus.if_id_rt));

    // Mealy next-state and control outputs; imem wait outranks the hazard, which outranks a branch
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        wait_cnt_d = wait_cnt_q;
        pc_next    = bus.pc_plus4;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        if_flush   = 1'b0;
        bubble     = 1'b0;
        if (rst) begin
            pc_next    = 32'd0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            if_flush   = 1'b1;
            bubble     = 1'b1;
        end else if (state_q == BOOT) begin
            pc_next    = 32'd0;
            ifid_write = 1'b0;
            if_flush   = 1'b1;
            bubble     = 1'b1;
            boot_cnt_d = boot_cnt_q + 1'b1;
            state_d    = (boot_cnt_q == BW'(BOOT_CYCLES - 1)) ? RUN : BOOT;
        end else if (!bus.imem_ready) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
            wait_cnt_d = (wait_cnt_q == WW'(WAIT_TIMEOUT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
            state_d    = RUN;
            if (state_q == RUN && hazard) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                bubble     = 1'b1;
                state_d    = LU_STALL;
            end else if (bus.branch_taken) begin
                pc_next  = bus.branch_target;
                if_flush = 1'b1;
            end
        end
    end

    // Stall statistics: saturating stall counter and sticky timeout
    always_comb begin
        stall_count_d = (state_q != BOOT && !pc_write && !(&stall_count_q)) ?
                        stall_count_q + 1'b1 : stall_count_q;
        timeout_d     = timeout_q | (wait_cnt_d == WW'(WAIT_TIMEOUT));
    end

    // State and counter registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            boot_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            stall_count_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.pc_next      = pc_next;
    assign bus.PCWrite      = pc_write;
    assign bus.IFIDWrite    = ifid_write;
    assign bus.IF_Flush     = if_flush;
    assign bus.ID_EX_bubble = bubble;
    assign bus.stall_count  = stall_count_q;
    assign bus.timeout_flag = timeout_q;
endmodule

// File: tb/tb_pc_stall_sequencer.sv
// tb_pc_stall_sequencer: directed scoreboard bench for pc_stall_sequencer
module tb_pc_stall_sequencer;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic        cpc;
        logic [31:0] pc;
        logic        pw;
        logic        iw;
        logic        fl;
        logic        bb;
    } ctl_t;

    ctl_t  exp_q[$];
    string tag_q[$];

    pc_stall_sequencer_if #(.CNT_W(16)) b0 ();
    pc_stall_sequencer_if #(.CNT_W(4))  b1 ();

    assign b1.pc_plus4       = b0.pc_plus4;
    assign b1.branch_taken   = b0.branch_taken;
    assign b1.branch_target  = b0.branch_target;
    assign b1.id_ex_mem_read = b0.id_ex_mem_read;
    assign b1.id_ex_rd       = b0.id_ex_rd;
    assign b1.if_id_rs       = b0.if_id_rs;
    assign b1.if_id_rt       = b0.if_id_rt;
    assign b1.imem_ready     = b0.imem_ready;

    pc_stall_sequencer u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    pc_stall_sequencer #(.CNT_W(4)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t ctl(input logic [31:0] pc, input logic pw, iw, fl, bb);
        return '{cpc: 1'b1, pc: pc, pw: pw, iw: iw, fl: fl, bb: bb};
    endfunction

    function automatic ctl_t stl();
        return '{cpc: 1'b0, pc: 32'd0, pw: 1'b0, iw: 1'b0, fl: 1'b0, bb: 1'b1};
    endfunction

    task automatic set_in(input logic rdy, mr, input logic [4:0] rd, rs, rt,
                          input logic br, input logic [31:0] tgt, pc4);
        b0.imem_ready     = rdy;
        b0.id_ex_mem_read = mr;
        b0.id_ex_rd       = rd;
        b0.if_id_rs       = rs;
        b0.if_id_rt       = rt;
        b0.branch_taken   = br;
        b0.branch_target  = tgt;
        b0.pc_plus4       = pc4;
    endtask

    task automatic compare_ctl();
        ctl_t  e;
        ctl_t  o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = '{cpc: e.cpc, pc: e.cpc ? b0.pc_next : e.pc, pw: b0.PCWrite, iw: b0.IFIDWrite,
              fl: b0.IF_Flush, bb: b0.ID_EX_bubble};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed pc=%h pw=%b iw=%b fl=%b bb=%b expected pc=%h pw=%b iw=%b fl=%b bb=%b",
                   t, o.pc, o.pw, o.iw, o.fl, o.bb, e.pc, e.pw, e.iw, e.fl, e.bb);
        end
    endtask

    task automatic step(input string tag, input ctl_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        compare_ctl();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0, 32'h4);
        repeat (3) step("reset", ctl(0, 0, 0, 1, 1));
        chk("rst_cnt", 32'(b0.stall_count), 0);
        chk("rst_to", 32'(b0.timeout_flag), 0);
        rst = 1'b0;
        repeat (2) step("boot", ctl(0, 1, 0, 1, 1));
        step("run0", ctl(32'h4, 1, 1, 0, 0));
        chk("cnt_run0", 32'(b0.stall_count), 0);

        set_in(1, 1, 8, 3, 8, 0, 0, 32'h8);
        step("lu_stall", stl());
        step("lu_once", ctl(32'h8, 1, 1, 0, 0));
        chk("cnt_lu", 32'(b0.stall_count), 1);
        set_in(1, 1, 0, 0, 0, 0, 0, 32'hc);
        step("lu_rd0", ctl(32'hc, 1, 1, 0, 0));
        set_in(1, 1, 5, 5, 9, 0, 0, 32'h10);
        step("lu_rs", stl());
        set_in(1, 0, 0, 0, 0, 0, 0, 32'h10);
        step("lu_rs_next", ctl(32'h10, 1, 1, 0, 0));
        chk("cnt_lu_rs", 32'(b0.stall_count), 2);

        set_in(1, 0, 0, 0, 0, 1, 32'h40, 32'h14);
        step("branch", ctl(32'h40, 1, 1, 1, 0));
        set_in(1, 0, 0, 0, 0, 0, 32'h40, 32'h44);
        step("branch_next", ctl(32'h44, 1, 1, 0, 0));
        set_in(1, 1, 8, 1, 8, 1, 32'h40, 32'h48);
        step("br_lu_stall", stl());
        step("br_after_stall", ctl(32'h40, 1, 1, 1, 0));
        chk("cnt_br_lu", 32'(b0.stall_count), 3);

        set_in(0, 0, 0, 0, 0, 0, 0, 32'h50);
        repeat (4) step("wait", ctl(32'h50, 0, 0, 0, 1));
        set_in(0, 1, 8, 1, 8, 0, 0, 32'h50);
        step("wait_over_haz", ctl(32'h50, 0, 0, 0, 1));
        chk("cnt_wait5", 32'(b0.stall_count), 8);
        chk("to_wait5", 32'(b0.timeout_flag), 0);
        set_in(1, 1, 8, 1, 8, 0, 0, 32'h50);
        step("haz_after_wait", stl());
        set_in(0, 1, 8, 1, 8, 0, 0, 32'h50);
        repeat (2) step("lu_wait", ctl(32'h50, 0, 0, 0, 1));
        set_in(1, 1, 8, 1, 8, 0, 0, 32'h54);
        step("lu_release", ctl(32'h54, 1, 1, 0, 0));
        chk("cnt_lu_wait", 32'(b0.stall_count), 11);
        set_in(1, 0, 0, 0, 0, 0, 0, 32'h58);
        step("run_again", ctl(32'h58, 1, 1, 0, 0));

        set_in(0, 0, 0, 0, 0, 0, 0, 32'h5c);
        repeat (63) step("to_wait", ctl(32'h5c, 0, 0, 0, 1));
        chk("to_63", 32'(b0.timeout_flag), 0);
        step("to_wait64", ctl(32'h5c, 0, 0, 0, 1));
        chk("to_64", 32'(b0.timeout_flag), 1);
        set_in(1, 0, 0, 0, 0, 0, 0, 32'h5c);
        step("to_release", ctl(32'h5c, 1, 1, 0, 0));
        chk("to_sticky", 32'(b0.timeout_flag), 1);
        chk("cnt_to", 32'(b0.stall_count), 75);

        set_in(1, 1, 8, 1, 8, 0, 0, 32'h60);
        step("pre_rst_stall", stl());
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(ctl(0, 0, 0, 1, 1));
        tag_q.push_back("async_rst");
        compare_ctl();
        chk("async_rst_cnt", 32'(b0.stall_count), 0);
        chk("async_rst_to", 32'(b0.timeout_flag), 0);
        chk("async_rst_cnt4", 32'(b1.stall_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(1, 0, 0, 0, 0, 0, 0, 32'h4);
        repeat (2) step("reboot", ctl(0, 1, 0, 1, 1));
        step("rerun", ctl(32'h4, 1, 1, 0, 0));

        set_in(0, 0, 0, 0, 0, 0, 0, 32'h8);
        repeat (15) step("sat_wait", ctl(32'h8, 0, 0, 0, 1));
        chk("sat_15", 32'(b1.stall_count), 15);
        repeat (5) step("sat_wait", ctl(32'h8, 0, 0, 0, 1));
        chk("sat_hold", 32'(b1.stall_count), 15);
        chk("cnt_20", 32'(b0.stall_count), 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
